// File: rtl/gshare_predictor_p.sv
// gshare direction predictor: PC^GHR-indexed 2-bit PHT with speculative GHR repair, sweep init; 1-cycle IF->ID prediction, no backpressure (stall_d/flush_d only).
// Optional BP_PERF_CNT_EN adds branch/mispredict performance counters.
module gshare_predictor_p #(
  parameter int         IDX_W    = 10,
  parameter int         GHR_W    = 8,
  parameter logic [1:0] INIT_CTR = 2'b10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall_d,
  input  logic             flush_d,
  input  logic [31:0]      pc_f,
  input  logic             branch_d,
  output logic             pred_take_d,
  output logic [IDX_W-1:0] pred_idx_d,
  output logic [GHR_W-1:0] pred_ghr_d,
  input  logic             upd_valid,
  input  logic [IDX_W-1:0] upd_idx,
  input  logic [GHR_W-1:0] upd_ghr,
  input  logic             upd_taken,
  input  logic             upd_mispred,
  output logic             ready
`ifdef BP_PERF_CNT_EN
  ,
  output logic [31:0]      perf_branches,
  output logic [31:0]      perf_mispred
`endif
);

  typedef enum logic {INIT, RUN} state_t;

  state_t           state;
  logic [IDX_W-1:0] sweepCnt;
  logic [GHR_W-1:0] specGhr;
  logic             takeD;
  logic [1:0]       pht [0:(1<<IDX_W)-1];

  logic [IDX_W-1:0] idxF;
  logic             takeF;
  logic             wrEn;
  logic [IDX_W-1:0] wrIdx;
  logic [1:0]       wrDat;
  logic [1:0]       curCtr;
  logic             unusedPcBits;

  assign unusedPcBits = ^{pc_f[31:IDX_W+2], pc_f[1:0]};

  function automatic logic [GHR_W-1:0] shiftIn(input logic [GHR_W-1:0] h, input logic b);
    return GHR_W'({h, b});
  endfunction

  assign ready       = (state == RUN);
  assign idxF        = pc_f[IDX_W+1:2] ^ IDX_W'(specGhr);
  assign takeF       = ready ? pht[idxF][1] : 1'b0;
  assign pred_take_d = branch_d & takeD;
  assign curCtr      = pht[upd_idx];

  // Single write port shared by the init sweep and EX-stage training.
  always_comb begin
    wrEn  = 1'b0;
    wrIdx = upd_idx;
    wrDat = curCtr;
    if (rst_n) begin
      if (state == INIT) begin
        wrEn  = 1'b1;
        wrIdx = sweepCnt;
        wrDat = INIT_CTR;
      end else if (upd_valid) begin
        wrEn = 1'b1;
        if (upd_taken)
          wrDat = (curCtr == 2'b11) ? 2'b11 : curCtr + 2'd1;
        else
          wrDat = (curCtr == 2'b00) ? 2'b00 : curCtr - 2'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wrEn)
      pht[wrIdx] <= wrDat;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= INIT;
      sweepCnt <= '0;
    end else if (state == INIT) begin
      sweepCnt <= sweepCnt + IDX_W'(1);
      if (sweepCnt == '1)
        state <= RUN;
    end
  end

  // Mispredict repair takes priority over a same-cycle ID-stage shift.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      specGhr <= '0;
    end else if (state == RUN) begin
      if (upd_valid && upd_mispred)
        specGhr <= shiftIn(upd_ghr, upd_taken);
      else if (branch_d && !stall_d && !flush_d)
        specGhr <= shiftIn(specGhr, pred_take_d);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || flush_d) begin
      takeD      <= 1'b0;
      pred_idx_d <= '0;
      pred_ghr_d <= '0;
    end else if (!stall_d) begin
      takeD      <= takeF;
      pred_idx_d <= idxF;
      pred_ghr_d <= specGhr;
    end
  end

`ifdef BP_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_branches <= '0;
      perf_mispred  <= '0;
    end else if (state == RUN && upd_valid) begin
      perf_branches <= perf_branches + 32'd1;
      if (upd_mispred)
        perf_mispred <= perf_mispred + 32'd1;
    end
  end
`endif

endmodule

// File: doc/gshare_predictor_p.md
Name: gshare_predictor_p

Overview:
- Parametrised gshare direction predictor: the successor to the fixed 20-bit global-history predictor in the 5-stage MIPS core (IF | ID | EX | MEM | WB).
- Predicts in IF from a PC-xor-speculative-GHR index and registers the result into ID.
- Trains 2-bit saturating counters from EX using the index and history carried down the pipe.
- Repairs the speculative GHR on mispredict; initialises the PHT with a sweep state machine instead of a single-cycle reset of the whole array.

Parameters:
- IDX_W, 10, PHT index width; PHT has 2^IDX_W 2-bit entries.
- GHR_W, 8, global history length; must satisfy 1 <= GHR_W <= IDX_W.
- INIT_CTR, 2'b10, counter value written by the init sweep (weakly taken).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  synchronous reset, active-low.
- stall_d  in  1  hold the ID-stage prediction registers.
- flush_d  in  1  clear the ID-stage prediction registers.
- pc_f  in  32  IF-stage PC.
- branch_d  in  1  ID-stage instruction is a conditional branch.
- pred_take_d  out  1  prediction for the ID-stage instruction, already gated by branch_d.
- pred_idx_d  out  IDX_W  PHT index used for this prediction; the pipeline carries it to EX.
- pred_ghr_d  out  GHR_W  speculative GHR value at prediction time; the pipeline carries it to EX.
- upd_valid  in  1  EX-stage branch resolved this cycle.
- upd_idx  in  IDX_W  carried pred_idx.
- upd_ghr  in  GHR_W  carried pred_ghr.
- upd_taken  in  1  actual branch outcome.
- upd_mispred  in  1  prediction was wrong.
- ready  out  1  init sweep complete; predictor active.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state <= INIT, sweep counter <= 0, spec GHR <= 0.
  - ID registers <= 0, so pred_take_d=0, pred_idx_d=0, pred_ghr_d=0.
  - ready=0.
- FSM INIT:
  - Each cycle writes INIT_CTR to PHT[sweep counter], then increments the counter.
  - After writing entry 2^IDX_W-1 the FSM moves to RUN; ready=1 from the next cycle.
  - The sweep takes exactly 2^IDX_W cycles after rst_n rises.
  - In INIT: the PHT read result is forced to 0 (not taken), upd_valid is ignored, and GHR holds at 0.
- FSM RUN: terminal state; only rst_n leaves it. rst_n low mid-sweep or mid-run restarts INIT from entry 0.
- Index (IF, combinational):
  - idx_f = pc_f[IDX_W+1:2] XOR {zero-extend GHR to IDX_W}.
  - take_f = PHT[idx_f][1] when ready, else 0.
- ID registers, updated at clk:
  - Priority: rst_n low, then flush_d (all cleared to 0), then stall_d (hold), otherwise load {take_f, idx_f, GHR}.
  - pred_take_d = branch_d & registered take; 1-cycle latency from pc_f.
- Speculative GHR, updated at clk, RUN only, priority order:
  1. upd_valid & upd_mispred: GHR <= {upd_ghr[GHR_W-2:0], upd_taken}. Repair wins over a same-cycle ID shift.
  2. branch_d & ~stall_d & ~flush_d: GHR <= {GHR[GHR_W-2:0], pred_take_d}.
  3. Otherwise hold.
  - When GHR_W=1 the shift reduces to loading the new bit.
- PHT training (RUN, upd_valid):
  - PHT[upd_idx] saturating update: +1 if upd_taken, -1 otherwise.
  - Clamped at 2'b11 and 2'b00.
- Read/write collision: when a same-cycle write hits idx_f, the prediction returns the old value. No forwarding.
- Exactly one PHT write port and one read port.

Optional Feature:
- Macro BP_PERF_CNT_EN.
- Defined: adds outputs perf_branches[31:0] and perf_mispred[31:0].
  - perf_branches increments on upd_valid in RUN.
  - perf_mispred increments on upd_valid & upd_mispred in RUN.
  - Both wrap modulo 2^32 and clear on reset, including mid-sweep.
- Undefined: the ports and counters do not exist; all other behaviour is identical.

Test Plan (IDX_W=4, GHR_W=4):
- Release rst_n, hold pc_f=0 -> ready=0 for 16 cycles, then ready=1; pred_take_d=0 throughout INIT; first RUN prediction with branch_d=1 -> pred_take_d=1 (INIT_CTR=10).
- RUN, GHR=0: three upd_valid, upd_idx=5, upd_taken=0 -> PHT[5] goes 10->01->00->00; pc_f=0x14 then gives pred_take_d=0.
- branch_d=1 with pred_take_d=1 for 3 cycles from GHR=0 -> GHR=4'b0111; pred_ghr_d tracks the pre-shift values 0000, 0001, 0011.
- Same cycle: branch_d=1 and upd_valid=1, upd_mispred=1, upd_ghr=4'b0010, upd_taken=1 -> GHR=4'b0101 (repair wins).
- flush_d=1 alongside branch_d=1 -> pred_take_d=0 next cycle, GHR unchanged; stall_d=1 -> pred_idx_d holds while pc_f changes.
- rst_n low for 1 cycle at sweep entry 7 -> ready stays 0 a further 16 cycles; upd_valid during INIT leaves PHT at 10 and does not change GHR.
